// File: rtl/alsu_pkg.sv
// alsu_pkg: opcodes, FSM state and request
// classification helpers for the ALSU pipeline
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_OR,
    OP_XOR,
    OP_ADD,
    OP_MUL,
    OP_SHIFT,
    OP_ROT
  } op_e;

  localparam logic [2:0] OP_INV6 = 3'd6;
  localparam logic [2:0] OP_INV7 = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  function automatic logic is_inv(
    input logic [2:0] op,
    input logic       ra,
    input logic       rb
  );
    return ((ra | rb) && op[2:1] != 2'b00)
        || op == OP_INV6 || op == OP_INV7;
  endfunction

  function automatic logic is_sh(
    input logic [2:0] op
  );
    return op == OP_SHIFT || op == OP_ROT;
  endfunction

endpackage

// File: rtl/alsu_datapath.sv
// alsu_datapath: single-cycle result for every
// opcode except shift/rotate
module alsu_datapath
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 4,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cin_i,
  input  logic [2:0]         op_i,
  input  logic               red_a_i,
  input  logic               red_b_i,
  input  logic               byp_a_i,
  input  logic               byp_b_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               inv_o,
  output logic               byp_o
);

  localparam int OW     = 2 * WIDTH;
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  logic signed [OW-1:0] ax;
  logic signed [OW-1:0] bx;
  logic                 use_a;
  logic                 use_b;
  logic                 sel_a;

  assign ax    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign bx    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign inv_o = is_inv(op_i, red_a_i, red_b_i);
  assign byp_o = byp_a_i | byp_b_i;
  assign use_a = red_a_i & (~red_b_i | PRIO_A);
  assign use_b = red_b_i & ~use_a;
  assign sel_a = byp_a_i & (~byp_b_i | PRIO_A);

  always_comb begin
    res_o = '0;
    if (inv_o) begin
      res_o = '0;
    end else if (byp_o) begin
      res_o = sel_a ? ax : bx;
    end else begin
      unique case (op_i)
        OP_OR:
          res_o = use_a ? OW'(|a_i)
                : use_b ? OW'(|b_i)
                : ax | bx;
        OP_XOR:
          res_o = use_a ? OW'(^a_i)
                : use_b ? OW'(^b_i)
                : ax ^ bx;
        OP_ADD:
          res_o = ax + bx + OW'(FA_ON & cin_i);
        OP_MUL:
          res_o = ax * bx;
        default:
          res_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// alsu_pipe: registered ALSU with a multi-cycle
// bit-serial shifter and an error blink output
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 4,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WIDTH-1:0]      a,
  input  logic signed [WIDTH-1:0]      b,
  input  logic                         cin,
  input  logic                         serial_in,
  input  logic                         red_op_a,
  input  logic                         red_op_b,
  input  logic                         bypass_a,
  input  logic                         bypass_b,
  input  logic                         direction,
  input  logic [2:0]                   opcode,
  input  logic [$clog2(2*WIDTH)-1:0]   shamt,
  output logic                         out_valid,
  output logic signed [2*WIDTH-1:0]    out,
  output logic                         err,
  output logic [LED_W-1:0]             leds
);

  localparam int OW = 2 * WIDTH;
  localparam int SW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             cin_q, si_q, dir_q;
  logic             ra_q, rb_q, ba_q, bb_q;

  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    out_q, out_d;
  logic             pend_q, pend_d;
  logic             ov_q, ov_d;
  logic             err_q, err_d;
  logic [LED_W-1:0] leds_q, leds_d;

  logic             accept;
  logic             go_sh;
  logic [OW-1:0]    sh_val;
  logic [OW-1:0]    dp_res;
  logic             dp_inv, dp_byp;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = ov_q;
  assign out       = out_q;
  assign err       = err_q;
  assign leds      = leds_q;

  // Only a clean, non-bypassed shift with a nonzero
  // count takes the multi-cycle path.
  assign go_sh = is_sh(opcode)
              & ~is_inv(opcode, red_op_a, red_op_b)
              & ~(bypass_a | bypass_b)
              & (shamt != '0);

  alsu_datapath #(
    .WIDTH          (WIDTH),
    .INPUT_PRIORITY (INPUT_PRIORITY),
    .FULL_ADDER     (FULL_ADDER)
  ) u_dp (
    .a_i     (a_q),
    .b_i     (b_q),
    .cin_i   (cin_q),
    .op_i    (op_q),
    .red_a_i (ra_q),
    .red_b_i (rb_q),
    .byp_a_i (ba_q),
    .byp_b_i (bb_q),
    .res_o   (dp_res),
    .inv_o   (dp_inv),
    .byp_o   (dp_byp)
  );

  always_comb begin
    sh_val = out_q;
    unique case ({op_q[0], dir_q})
      2'b01: sh_val = {out_q[OW-2:0], si_q};
      2'b00: sh_val = {si_q, out_q[OW-1:1]};
      2'b11: sh_val = {out_q[OW-2:0], out_q[OW-1]};
      2'b10: sh_val = {out_q[0], out_q[OW-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    err_d   = err_q;
    pend_d  = accept & ~go_sh;
    unique case (state_q)
      S_IDLE: begin
        if (accept && go_sh) begin
          state_d = S_SHIFT;
          cnt_d   = shamt;
        end
      end
      S_SHIFT: begin
        out_d = sh_val;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = S_IDLE;
          ov_d    = 1'b1;
          err_d   = 1'b0;
        end
      end
    endcase
    if (pend_q) begin
      out_d = (dp_inv | dp_byp | ~is_sh(op_q))
            ? dp_res : out_q;
      ov_d  = 1'b1;
      err_d = dp_inv;
    end
    leds_d = err_d ? (err_q ? ~leds_q : '1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
      si_q  <= 1'b0;
      dir_q <= 1'b0;
      ra_q  <= 1'b0;
      rb_q  <= 1'b0;
      ba_q  <= 1'b0;
      bb_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      op_q  <= opcode;
      cin_q <= cin;
      si_q  <= serial_in;
      dir_q <= direction;
      ra_q  <= red_op_a;
      rb_q  <= red_op_b;
      ba_q  <= bypass_a;
      bb_q  <= bypass_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      leds_q  <= leds_d;
    end
  end

endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: directed and random checks of
// alsu_pipe against a transaction-level model
module tb_alsu_pipe;

  localparam int W  = 4;
  localparam int OW = 8;
  localparam int SW = 3;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          serial_in = 1'b0;
  logic          red_op_a = 1'b0;
  logic          red_op_b = 1'b0;
  logic          bypass_a = 1'b0;
  logic          bypass_b = 1'b0;
  logic          direction = 1'b0;
  logic [2:0]    opcode = '0;
  logic [SW-1:0] shamt = '0;
  logic          out_valid;
  logic [OW-1:0] dout;
  logic          err;
  logic [LW-1:0] leds;

  alsu_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .serial_in (serial_in),
    .red_op_a  (red_op_a),
    .red_op_b  (red_op_b),
    .bypass_a  (bypass_a),
    .bypass_b  (bypass_b),
    .direction (direction),
    .opcode    (opcode),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out       (dout),
    .err       (err),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
    bit e;
  } rsp_t;

  rsp_t q[$];
  int   cyc      = 0;
  int   busy_due = 0;
  int   held     = 0;
  int   last     = 0;
  int   age      = 0;
  bit   flag     = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Whole-transaction result straight from the operation rules.
  function automatic void model_accept();
    int   sa, sb, r, n, m, lat;
    bit   e;
    rsp_t t;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    e   = 1'b0;
    lat = 1;
    r   = 0;
    if (((red_op_a || red_op_b) && opcode >= 2) || opcode >= 6)
      e = 1'b1;
    else if (bypass_a) r = sa;
    else if (bypass_b) r = sb;
    else begin
      case (opcode)
        3'd0: r = red_op_a ? int'(a != 0)
                : red_op_b ? int'(b != 0) : (sa | sb);
        3'd1: r = red_op_a ? $countones(a) % 2
                : red_op_b ? $countones(b) % 2 : (sa ^ sb);
        3'd2: r = sa + sb + int'(cin);
        3'd3: r = sa * sb;
        default: begin
          n = int'(shamt);
          m = last;
          if (n == 0) r = m;
          else begin
            lat = n;
            if (opcode == 3'd4)
              r = direction
                ? (m << n) | (serial_in ? (1 << n) - 1 : 0)
                : (m >> n) | (serial_in ? (255 << (8 - n)) : 0);
            else
              r = direction
                ? (m << n) | (m >> (8 - n))
                : (m >> n) | (m << (8 - n));
            busy_due = cyc + 1 + n;
          end
        end
      endcase
    end
    r     = r & 255;
    last  = r;
    t.due = cyc + 1 + lat;
    t.val = r;
    t.e   = e;
    q.push_back(t);
  endfunction

  task automatic step();
    bit   ev;
    rsp_t t;
    if (in_valid && cyc >= busy_due) model_accept();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    ev = (q.size() > 0 && q[0].due == cyc);
    t  = '{0, 0, 1'b0};
    if (ev) begin
      t    = q.pop_front();
      held = t.val;
      if (t.e) begin
        if (!flag) age = 0;
        else age++;
      end
      flag = t.e;
    end else if (flag) age++;
    chk("in_ready", in_ready, cyc >= busy_due);
    chk("out_valid", out_valid, ev);
    if (ev) chk("err", err, t.e);
    if (cyc >= busy_due) chk("out", dout, held);
    chk("leds", leds,
        flag ? ((age % 2 == 0) ? 16'hFFFF : 16'h0000) : 16'h0);
  endtask

  task automatic clr();
    a = '0; b = '0; cin = 0; serial_in = 0;
    red_op_a = 0; red_op_b = 0; bypass_a = 0; bypass_b = 0;
    direction = 0; opcode = '0; shamt = '0;
  endtask

  task automatic go();
    int guard;
    guard = 0;
    while (cyc < busy_due && guard < 50) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_out", dout, 8'h00);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_leds", leds, 16'h0);
    rst = 1'b0;

    clr(); a = 4'd3; b = 4'hE; cin = 1; opcode = 3'd2;
    go(); step();
    chk("add_out", dout, 8'h02);
    chk("add_ov", out_valid, 1'b1);

    clr(); a = 4'h8; b = 4'd7; opcode = 3'd3;
    go(); step();
    chk("mul_out", dout, 8'hC8);
    chk("mul_err", err, 1'b0);

    clr(); a = 4'd1; opcode = 3'd2;
    go(); step();
    clr(); opcode = 3'd4; direction = 1; serial_in = 1; shamt = 3'd3;
    go();
    chk("shift_busy", in_ready, 1'b0);
    repeat (3) step();
    chk("shift_out", dout, 8'h0F);
    chk("shift_ov", out_valid, 1'b1);

    clr(); red_op_a = 1; opcode = 3'd2;
    go(); step();
    chk("inv_out", dout, 8'h00);
    chk("inv_err", err, 1'b1);
    chk("inv_led0", leds, 16'hFFFF);
    step();
    chk("inv_led1", leds, 16'h0000);
    step();
    clr(); a = 4'd5; opcode = 3'd0;
    go(); step();
    chk("led_clr", leds, 16'h0);
    chk("or_out", dout, 8'h05);

    clr(); bypass_a = 1; bypass_b = 1; a = 4'hF; b = 4'd2;
    go(); step();
    chk("byp_out", dout, 8'hFF);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      serial_in = 1'($urandom);
      direction = 1'($urandom);
      opcode    = 3'($urandom);
      shamt     = SW'($urandom);
      red_op_a  = ($urandom % 8) == 0;
      red_op_b  = ($urandom % 8) == 0;
      bypass_a  = ($urandom % 8) == 0;
      bypass_b  = ($urandom % 8) == 0;
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();

    clr(); a = 4'd6; opcode = 3'd2;
    go(); step();
    clr(); opcode = 3'd5; shamt = 3'd5; direction = 1;
    go(); step();
    rst = 1'b1;
    #1;
    chk("mid_out", dout, 8'h00);
    chk("mid_ov", out_valid, 1'b0);
    chk("mid_ready", in_ready, 1'b1);
    chk("mid_err", err, 1'b0);
    chk("mid_leds", leds, 16'h0);
    q.delete();
    busy_due = 0; held = 0; last = 0; flag = 0; age = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alsu_pipe.md
ALSU_PIPE -- requirements
Module: alsu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: signed operand width, min 3.
REQ-002 The block SHALL have parameter INPUT_PRIORITY, default "A": operand chosen when both bypass or both red_op flags are set.
REQ-003 The block SHALL have parameter FULL_ADDER, default "ON": "ON" adds cin, "OFF" ignores it.
REQ-004 The block SHALL have parameter LED_W, default 16: leds width.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block can accept.
REQ-009 The block SHALL have ports a and b, input, WIDTH bits each: signed operands.
REQ-010 The block SHALL have ports cin, serial_in, red_op_a, red_op_b, bypass_a, bypass_b and direction, input, 1 bit each; direction=1 means left.
REQ-011 The block SHALL have port opcode, input, 3 bits: 0 OR, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE.
REQ-012 The block SHALL have port shamt, input, clog2(2*WIDTH) bits: shift/rotate count.
REQ-013 The block SHALL have port out_valid, output, 1 bit: one-cycle result strobe.
REQ-014 The block SHALL have port out, output, 2*WIDTH bits: signed result, held between transactions.
REQ-015 The block SHALL have port err, output, 1 bit: qualified by out_valid; set for an invalid request.
REQ-016 The block SHALL have port leds, output, LED_W bits: error blink.

Function
REQ-017 The block SHALL accept a request on a clock edge where in_valid and in_ready are both 1, registering every request input.
REQ-018 The block SHALL implement an FSM with states IDLE and SHIFT; in_ready SHALL be 1 only in IDLE.
REQ-019 For an opcode other than 4/5, and for opcode 4/5 with shamt=0, the block SHALL update out and pulse out_valid at the edge after acceptance, stay in IDLE and allow back-to-back acceptance every cycle.
REQ-020 For opcode 4/5 with shamt=n>=1 and no bypass, the block SHALL enter SHIFT, move out by one bit per cycle for n cycles, return to IDLE and pulse out_valid with the final value n edges after acceptance.
REQ-021 SHIFT SHALL insert serial_in at bit 0 when direction=1 and at the MSB when direction=0; ROTATE SHALL recirculate the exiting bit; both operate on the current out.
REQ-022 The block SHALL treat a request as invalid when (red_op_a|red_op_b) and opcode[2:1]!=0, or when opcode is 6 or 7.
REQ-023 Result priority SHALL be: invalid (out=0, err=1), then bypass (bypass operand sign-extended), then opcode.
REQ-024 For OR/XOR the block SHALL use the sign-extended operands; a red_op flag SHALL select the reduction of that operand, zero-extended, with INPUT_PRIORITY deciding when both flags are set.
REQ-025 ADD SHALL produce the sign-extended a+b, plus cin when FULL_ADDER="ON", with a 2*WIDTH result and no overflow possible.
REQ-026 MUL SHALL produce the full signed 2*WIDTH product.
REQ-027 An error flag SHALL be set on an invalid response and cleared on the next valid response; while it is set, leds SHALL invert every cycle, starting from all-ones on the first cycle, and otherwise leds SHALL be 0.
REQ-028 in_valid SHALL be ignored while in_ready=0; the request is neither captured nor lost-acknowledged.

Reset
REQ-029 When rst is asserted, the block SHALL immediately set the FSM to IDLE and drive out=0, out_valid=0, err=0, leds=0, in_ready=1, and clear the error flag and all input registers, including when a shift is in progress.

Structure
REQ-030 Package alsu_pkg SHALL hold the opcode enum, the FSM state typedef and the invalid-opcode constants.
REQ-031 The combinational result for every opcode other than 4/5 SHALL sit in sub-module alsu_datapath; the FSM, the shifter and leds SHALL stay in alsu_pipe.

Verification
REQ-032 With WIDTH=4, a=3, b=-2, cin=1, opcode=2: out=2 and out_valid one cycle after acceptance.
REQ-033 With a=-8, b=7, opcode=3: out=0xC8 (-56), err=0.
REQ-034 With out=0x01 held, opcode=4, direction=1, serial_in=1, shamt=3: in_ready low for 3 cycles, then out=0x0F with out_valid.
REQ-035 With red_op_a=1, opcode=2: out=0 and err=1; leds alternate 0xFFFF/0x0000 until an OR request is accepted, then leds=0.
REQ-036 With rst asserted on the second cycle of a shamt=5 rotate: out=0, out_valid=0 and in_ready=1 immediately; no late out_valid.
REQ-037 With bypass_a=bypass_b=1, a=-1, b=2, INPUT_PRIORITY="A": out=0xFF.
